// File: rtl/pipe_fetch_stage.sv
// -----------------------------------------------------------------------------
// pipe_fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register.
//   - Holds the fetch PC and issues word fetches to an in-order,
//     variable-latency instruction memory.
//   - Returned words are buffered in a small prefetch FIFO, tagged with PC+4.
//   - The decode stage can hold IF/ID (stall) or redirect fetch (pcsource).
//     A redirect flushes the FIFO and discards every response still in
//     flight for the wrong path.
//
// Ports
//   clk          clock, rising edge
//   clrn         asynchronous active-low reset
//   stall        decode hold request; freezes IF/ID and the FIFO head
//   pcsource     00 sequential, 01 bpc, 10 ra, 11 jpc
//   bpc/jpc/ra   redirect targets
//   imem_req     fetch request valid
//   imem_addr    fetch address (word aligned)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  read data valid (in order, >= 1 cycle after acceptance)
//   imem_rdata   instruction word
//   dpc4         IF/ID: PC+4 of the held instruction
//   inst         IF/ID: instruction word, 0 on a bubble
//   id_valid     IF/ID holds a real instruction
//   fpc          current fetch PC
// -----------------------------------------------------------------------------
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        id_valid,
  output logic [31:0] fpc
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;          // counters must reach FIFO_DEPTH itself
  localparam int CW1 = CW + 1;          // sum of two counters
  localparam logic [CW1-1:0] DEPTH_W = CW1'(FIFO_DEPTH);

  // Architectural state
  logic [31:0]   fpc_reg,         fpc_next;
  logic [31:0]   resp_pc_reg,     resp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg,    drop_cnt_next;
  logic [CW-1:0] fifo_count_reg,  fifo_count_next;
  logic [AW-1:0] wr_ptr_reg,      wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg,      rd_ptr_next;
  logic [31:0]   dpc4_reg,        dpc4_next;
  logic [31:0]   inst_reg,        inst_next;
  logic          id_valid_reg,    id_valid_next;

  // Prefetch storage: {pc+4, instruction}
  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [63:0]   fifo_head;
  logic [63:0]   push_data;

  logic          redirect;
  logic          credit_ok;
  logic          accept;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [31:0]   target;
  logic [CW1-1:0] credit_used;

  // Redirect is only honoured for a real instruction that is leaving IF/ID.
  assign redirect    = id_valid_reg & ~stall & (pcsource != 2'b00);

  // Every request in flight owns a FIFO slot, so a push can never overflow.
  assign credit_used = {1'b0, fifo_count_reg} + {1'b0, outstanding_reg};
  assign credit_ok   = credit_used < DEPTH_W;

  // Gated by clrn so no request is shown while reset is held.
  assign imem_req    = clrn & ~redirect & credit_ok;
  assign imem_addr   = fpc_reg;
  assign accept      = imem_req & imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp         = imem_rvalid & (outstanding_reg != '0);
  // Wrong-path data: either still owed to an earlier redirect, or arriving
  // in the redirect cycle itself.
  assign drop        = rsp & ((drop_cnt_reg != '0) | redirect);
  assign push        = rsp & ~drop;
  assign pop         = ~redirect & ~stall & (fifo_count_reg != '0);

  assign push_data   = {resp_pc_reg + 32'd4, imem_rdata};
  assign fifo_head   = fifo_mem[rd_ptr_reg];

  always_comb begin
    target = jpc;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = ra;
      default: target = jpc;
    endcase
  end

  always_comb begin
    fpc_next         = fpc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CW'(accept) - CW'(rsp);
    drop_cnt_next    = drop_cnt_reg;
    fifo_count_next  = fifo_count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    dpc4_next        = dpc4_reg;
    inst_next        = inst_reg;
    id_valid_next    = id_valid_reg;

    if (redirect) begin
      fpc_next        = target;
      resp_pc_next    = target;
      // Everything still in flight after this edge belongs to the old path.
      drop_cnt_next   = outstanding_next;
      fifo_count_next = '0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      inst_next       = '0;
      id_valid_next   = 1'b0;
    end else begin
      if (accept) fpc_next = fpc_reg + 32'd4;
      if (drop)   drop_cnt_next = drop_cnt_reg - CW'(1);
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        wr_ptr_next  = wr_ptr_reg + AW'(1);
      end
      if (pop) rd_ptr_next = rd_ptr_reg + AW'(1);
      fifo_count_next = fifo_count_reg + CW'(push) - CW'(pop);

      if (!stall) begin
        if (pop) begin
          dpc4_next     = fifo_head[63:32];
          inst_next     = fifo_head[31:0];
          id_valid_next = 1'b1;
        end else begin
          // Bubble: dpc4 deliberately keeps its last value.
          inst_next     = '0;
          id_valid_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fpc_reg         <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      dpc4_reg        <= '0;
      inst_reg        <= '0;
      id_valid_reg    <= 1'b0;
    end else begin
      fpc_reg         <= fpc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      fifo_count_reg  <= fifo_count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      dpc4_reg        <= dpc4_next;
      inst_reg        <= inst_next;
      id_valid_reg    <= id_valid_next;
    end
  end

  // Storage needs no reset: the count and pointers define which entries
  // are live, and push cannot fire while reset holds outstanding at zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_data;
  end

  assign dpc4     = dpc4_reg;
  assign inst     = inst_reg;
  assign id_valid = id_valid_reg;
  assign fpc      = fpc_reg;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_stage
//   Drives pipe_fetch_stage with a behavioural in-order memory and a decode
//   stage that stalls and redirects. The driver pushes the architecturally
//   expected PC of each instruction into a queue; an independent monitor pops
//   it whenever IF/ID hands an instruction on to decode.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] dpc4, inst, fpc;
  logic        id_valid;

  always #5 clk = ~clk;

  pipe_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .ra(ra),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dpc4(dpc4), .inst(inst), .id_valid(id_valid), .fpc(fpc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks   = 0;
  int          failures = 0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  // Stimulus knobs
  bit          k_ready_rand;
  int          k_dmin, k_dmax;
  bit          k_stall;
  logic [1:0]  k_pcsrc;
  logic [31:0] k_tgt;

  // Model / bookkeeping
  int          cyc = 0;
  int          last_due;
  int          since_rst;
  int          n_deliv;
  int          acc_stall;
  bit          lat_chk;
  bit          last_req;
  bit          redir_pend;
  logic [31:0] redir_tgt;
  logic [31:0] arch_pc;
  logic [31:0] fetch_model;
  bit          prev_stall;
  logic [31:0] prev_dpc4, prev_inst;
  logic        prev_idv;
  logic [31:0] mon_e;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of decode + memory behaviour, driven at the falling edge.
  task automatic step();
    bit          redir;
    int          d, due;
    logic [31:0] tgt;
    @(negedge clk);
    if (clrn) begin
      if (redir_pend) begin
        chk(id_valid == 1'b0, "redirect_bubble_valid", 32'(id_valid), 32'd0);
        chk(inst == 32'h0, "redirect_bubble_inst", inst, 32'h0);
        chk(fpc == redir_tgt, "redirect_fpc", fpc, redir_tgt);
      end
      if (prev_stall) begin
        chk(dpc4 == prev_dpc4, "stall_hold_dpc4", dpc4, prev_dpc4);
        chk(inst == prev_inst, "stall_hold_inst", inst, prev_inst);
        chk(id_valid == prev_idv, "stall_hold_valid", 32'(id_valid), 32'(prev_idv));
      end
      if (lat_chk && (since_rst == 1 || since_rst == 2))
        chk(id_valid == 1'b0, "latency_early_valid", 32'(id_valid), 32'd0);
      if (lat_chk && since_rst == 3) begin
        chk(id_valid == 1'b1, "latency_first_valid", 32'(id_valid), 32'd1);
        chk(dpc4 == RESET_PC + 32'd4, "latency_first_dpc4", dpc4, RESET_PC + 32'd4);
      end
    end
    clrn = 1'b1;
    since_rst++;
    redir_pend = 1'b0;

    // Decode side
    stall    = k_stall;
    tgt      = k_tgt;
    pcsource = 2'b00;
    if (id_valid && k_pcsrc != 2'b00) pcsource = k_pcsrc;
    bpc = (pcsource == 2'b01) ? tgt : tgt ^ 32'h0000_0800;
    ra  = (pcsource == 2'b10) ? tgt : tgt ^ 32'h0000_1000;
    jpc = (pcsource == 2'b11) ? tgt : tgt ^ 32'h0000_2000;
    redir = id_valid && !stall && (pcsource != 2'b00);
    if (id_valid && !stall) begin
      arch_pc = redir ? tgt : arch_pc + 32'd4;
      exp_q.push_back(arch_pc);
    end
    if (redir) k_pcsrc = 2'b00;

    // Memory side: in-order responses once due
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    imem_ready = k_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    #1;
    if (redir) chk(imem_req == 1'b0, "req_blocked_on_redirect", 32'(imem_req), 32'd0);
    if (imem_req) chk(imem_addr == fetch_model, "imem_addr", imem_addr, fetch_model);
    last_req = imem_req;
    if (imem_req && imem_ready) begin
      d   = $urandom_range(k_dmin, k_dmax);
      due = cyc + d;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{fetch_model, due});
      fetch_model = fetch_model + 32'd4;
      if (stall) acc_stall++;
    end
    if (redir) begin
      fetch_model = tgt;
      redir_pend  = 1'b1;
      redir_tgt   = tgt;
    end
    chk(mem_q.size() <= FIFO_DEPTH, "credit_limit", 32'(mem_q.size()), 32'(FIFO_DEPTH));
    prev_stall = stall;
    prev_dpc4  = dpc4;
    prev_inst  = inst;
    prev_idv   = id_valid;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn        = 1'b0;
    stall       = 1'b0;
    pcsource    = 2'b00;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;
    bpc = 32'h0; ra = 32'h0; jpc = 32'h0;
    #1;
    chk(imem_req == 1'b0, "reset_imem_req", 32'(imem_req), 32'd0);
    chk(id_valid == 1'b0, "reset_id_valid", 32'(id_valid), 32'd0);
    chk(inst == 32'h0, "reset_inst", inst, 32'h0);
    chk(dpc4 == 32'h0, "reset_dpc4", dpc4, 32'h0);
    chk(fpc == RESET_PC, "reset_fpc", fpc, RESET_PC);
    mem_q.delete();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    arch_pc     = RESET_PC;
    fetch_model = RESET_PC;
    prev_stall  = 1'b0;
    redir_pend  = 1'b0;
    since_rst   = 0;
    n_deliv     = 0;
    k_pcsrc     = 2'b00;
    k_stall     = 1'b0;
    last_due    = cyc;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares each instruction handed to decode against the queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (clrn === 1'b1) begin
        if (id_valid && !stall) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "scoreboard_empty", dpc4, 32'h0);
          end else begin
            mon_e = exp_q.pop_front();
            chk(dpc4 == mon_e + 32'd4, "dpc4", dpc4, mon_e + 32'd4);
            chk(inst == memword(mon_e), "inst", inst, memword(mon_e));
          end
        end else if (id_valid === 1'b0) begin
          chk(inst == 32'h0, "bubble_inst_zero", inst, 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got t=%0t expected completion", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int guard;
    clrn = 1'b1; stall = 1'b0; pcsource = 2'b00;
    bpc = 32'h0; ra = 32'h0; jpc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    k_ready_rand = 1'b0; k_dmin = 1; k_dmax = 1; k_tgt = 32'h0;
    lat_chk = 1'b0; acc_stall = 0;

    // Zero-wait stream from reset: first instruction after 3 edges, then 1/cycle
    do_reset();
    lat_chk = 1'b1;
    repeat (20) step();
    lat_chk = 1'b0;
    #2;
    chk(n_deliv == 17, "zero_wait_throughput", 32'(n_deliv), 32'd17);

    // Stall for 6 cycles with the memory always ready
    k_stall = 1'b1; acc_stall = 0;
    repeat (6) step();
    chk(acc_stall <= FIFO_DEPTH, "stall_accept_limit", 32'(acc_stall), 32'(FIFO_DEPTH));
    chk(last_req == 1'b0, "stall_req_dropped", 32'(last_req), 32'd0);
    k_stall = 1'b0;
    repeat (10) step();

    // Branch via bpc=0x100 with a 3-cycle memory
    k_dmin = 3; k_dmax = 3;
    repeat (8) step();
    k_pcsrc = 2'b01; k_tgt = 32'h0000_0100;
    repeat (15) step();

    // Jump via jpc=0x40 requested while stalled
    k_dmin = 1; k_dmax = 1;
    repeat (6) step();
    k_stall = 1'b1; k_pcsrc = 2'b11; k_tgt = 32'h0000_0040;
    repeat (3) step();
    chk(k_pcsrc == 2'b11, "no_redirect_while_stalled", 32'(k_pcsrc), 32'd3);
    k_stall = 1'b0;
    repeat (10) step();

    // Random ready, 1-5 cycle latency, random stalls and jr redirects
    k_ready_rand = 1'b1; k_dmin = 1; k_dmax = 5; k_pcsrc = 2'b00;
    n_deliv = 0; guard = 0;
    while (n_deliv < 200 && guard < 4000) begin
      k_stall = ($urandom_range(0, 3) == 0);
      if (k_pcsrc == 2'b00 && $urandom_range(0, 9) == 0) begin
        k_pcsrc = 2'b10;
        k_tgt   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      step();
      guard++;
    end
    chk(n_deliv >= 200, "random_delivered", 32'(n_deliv), 32'd200);

    // Reset in the middle of a slow burst, then restart from RESET_PC
    k_ready_rand = 1'b0; k_stall = 1'b0; k_pcsrc = 2'b00;
    k_dmin = 3; k_dmax = 3;
    repeat (6) step();
    do_reset();
    k_dmin = 1; k_dmax = 1;
    lat_chk = 1'b1;
    repeat (12) step();
    lat_chk = 1'b0;
    #2;
    chk(n_deliv == 9, "restart_delivered", 32'(n_deliv), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
